bram_rr_arbiter: RTL

- Shares one 256x16 iCE40 block RAM (SB_RAM256x16 primitive, instantiated by the parent) between NUM_REQ requesters.
- Requesters use a valid/ready handshake. The arbiter grants one read or write per cycle, round-robin, and returns read data to the issuing requester.
- An optional post-reset clear sequencer writes CLEAR_VALUE to every word before the first grant.
- Sits between requester logic and the RAM netlist and drives all of the RAM's control, address, mask and data pins.

---
 rtl/bram_arb_pkg.sv | 42 ++++
 rtl/bram_rr_pick.sv | 30 +++
 rtl/bram_rr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the block-RAM round-robin arbiter family.
// rr_pick is the reusable round-robin scan for up to four requesters.
package bram_arb_pkg;

  localparam int RAM_DEPTH = 256;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo n (n <= 4, ptr < n).
  function automatic pick_t rr_pick(input logic [3:0] valid, input logic [1:0] ptr, input int n);
    pick_t      p;
    logic [2:0] j;
    p.found = 1'b0;
    p.idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      j = {1'b0, ptr} + 3'(k);
      if (j >= 3'(n)) begin
        j = j - 3'(n);
      end else begin
        j = j;
      end
      if ((k < n) && !p.found && valid[j[1:0]]) begin
        p.found = 1'b1;
        p.idx   = j[1:0];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Combinational round-robin priority selector shared by the resource arbiters.
// Produces the winning index, a found flag and a one-hot grant vector.
module bram_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         idx,
  output logic [NUM_REQ-1:0] grant
);
  import bram_arb_pkg::*;

  logic [3:0] valid_pad_s;
  pick_t      pick_s;

  // Scan from ptr and decode the winner to a one-hot grant.
  always_comb begin
    valid_pad_s                = 4'b0000;
    valid_pad_s[NUM_REQ-1:0]   = valid;
    pick_s                     = rr_pick(valid_pad_s, ptr, NUM_REQ);
    found                      = pick_s.found;
    idx                        = pick_s.idx;
    grant                      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = pick_s.found && (pick_s.idx == 2'(i));
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one 256x16 iCE40 block RAM between requesters,
// with an optional post-reset clear sweep and tagged read responses.
module bram_rr_arbiter #(
  parameter int                NUM_REQ        = 2,
  parameter int                ADDR_W         = bram_arb_pkg::ADDR_W,
  parameter int                DATA_W         = bram_arb_pkg::DATA_W,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0]  req_mask,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       busy,
  output logic                       ram_we,
  output logic                       ram_wclke,
  output logic                       ram_re,
  output logic                       ram_rclke,
  output logic [ADDR_W-1:0]          ram_waddr,
  output logic [ADDR_W-1:0]          ram_raddr,
  output logic [DATA_W-1:0]          ram_mask,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata
);
  import bram_arb_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_addr_r;
  logic [1:0]          rr_ptr_r;
  logic                found_s;
  logic [1:0]          idx_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic                xfer_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W-1:0]   sel_mask_s;
  logic [NUM_REQ-1:0]  read_tag_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rdata_hold_r;

  bram_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_r),
    .found (found_s),
    .idx   (idx_s),
    .grant (grant_s)
  );

  // Grant only while arbitrating; reset and the clear sweep block all requesters.
  always_comb begin
    if (!rst && (state_r == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    xfer_s = |req_ready;
  end

  // One-hot AND-OR mux of the winning requester's payload.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_mask_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we_s    = sel_we_s    | (req_we[i] & grant_s[i]);
      sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_mask_s  = sel_mask_s  | (req_mask[i*DATA_W +: DATA_W]  & {DATA_W{grant_s[i]}});
    end
  end

  // Control FSM, registered RAM command stage and the two-stage read tag pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_addr_r   <= '0;
      rr_ptr_r     <= 2'b00;
      ram_we       <= 1'b0;
      ram_wclke    <= 1'b0;
      ram_re       <= 1'b0;
      ram_rclke    <= 1'b0;
      ram_waddr    <= '0;
      ram_raddr    <= '0;
      ram_mask     <= '0;
      ram_wdata    <= '0;
      read_tag_r   <= '0;
      rsp_valid_r  <= '0;
      rdata_hold_r <= '0;
    end else begin
      rsp_valid_r <= read_tag_r;
      read_tag_r  <= '0;
      ram_we      <= 1'b0;
      ram_wclke   <= 1'b0;
      ram_re      <= 1'b0;
      ram_rclke   <= 1'b0;
      if (|rsp_valid_r) begin
        rdata_hold_r <= ram_rdata;
      end
      case (state_r)
        CLEAR: begin
          ram_we     <= 1'b1;
          ram_wclke  <= 1'b1;
          ram_waddr  <= clr_addr_r;
          ram_wdata  <= CLEAR_VALUE;
          ram_mask   <= '0;
          clr_addr_r <= clr_addr_r + ADDR_W'(1);
          if (clr_addr_r == LAST_ADDR) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (xfer_s) begin
            rr_ptr_r <= (idx_s == 2'(NUM_REQ - 1)) ? 2'b00 : idx_s + 2'b01;
            if (sel_we_s) begin
              ram_we    <= 1'b1;
              ram_wclke <= 1'b1;
              ram_waddr <= sel_addr_s;
              ram_wdata <= sel_wdata_s;
              ram_mask  <= sel_mask_s;
            end else begin
              ram_re     <= 1'b1;
              ram_rclke  <= 1'b1;
              ram_raddr  <= sel_addr_s;
              read_tag_r <= grant_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read data passes straight through on its response cycle, otherwise holds.
  always_comb begin
    if (|rsp_valid_r) begin
      rsp_rdata = ram_rdata;
    end else begin
      rsp_rdata = rdata_hold_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign busy      = (state_r == CLEAR);

endmodule
